// File: rtl/seq_mul_chunked.sv
// Multi-cycle chunked multiplier: one CHUNK x CHUNK partial product per clock
// is accumulated into a full-width sum, behind a valid/ready handshake.
module seq_mul_chunked #(
    parameter int unsigned A_WIDTH = 32,
    parameter int unsigned B_WIDTH = 32,
    parameter int unsigned CHUNK   = 16,
    parameter int unsigned SIGNED  = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [A_WIDTH-1:0]         A,
    input  logic [B_WIDTH-1:0]         B,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [A_WIDTH+B_WIDTH-1:0] Y
);

    // CH guards the derived divisions so a bad CHUNK reaches the check below
    localparam int unsigned CH = (CHUNK < 1) ? 1 : CHUNK;
    localparam int unsigned NA = A_WIDTH / CH;
    localparam int unsigned NB = B_WIDTH / CH;
    localparam int unsigned YW = A_WIDTH + B_WIDTH;
    localparam int unsigned PW = 2 * CH;
    localparam int unsigned IW = (NA > 1) ? $clog2(NA) : 1;
    localparam int unsigned JW = (NB > 1) ? $clog2(NB) : 1;

    generate
        if ((CHUNK < 1) || (A_WIDTH % CH != 0) || (B_WIDTH % CH != 0)
            || (A_WIDTH == 0) || (B_WIDTH == 0)) begin : g_bad_params
            $error("seq_mul_chunked: A_WIDTH and B_WIDTH must be non-zero multiples of CHUNK >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [A_WIDTH-1:0] r_a;
    logic [B_WIDTH-1:0] r_b;
    logic              r_neg;
    logic [IW-1:0]     r_i;
    logic [JW-1:0]     r_j;
    logic [YW-1:0]     r_acc;
    logic [YW-1:0]     r_y;
    logic              r_out_valid;

    logic              w_a_neg;
    logic              w_b_neg;
    logic [A_WIDTH-1:0] w_a_mag;
    logic [B_WIDTH-1:0] w_b_mag;
    logic [CH-1:0]     w_a_chunk;
    logic [CH-1:0]     w_b_chunk;
    logic [PW-1:0]     w_pp;
    logic [YW-1:0]     w_pp_sh;
    logic [YW-1:0]     w_acc_next;
    logic              w_i_last;
    logic              w_last;

    // Operand magnitudes; the most negative value maps onto its unsigned magnitude
    always_comb begin
        w_a_neg = (SIGNED != 0) && A[A_WIDTH-1];
        w_b_neg = (SIGNED != 0) && B[B_WIDTH-1];
        w_a_mag = w_a_neg ? A_WIDTH'(-A) : A;
        w_b_mag = w_b_neg ? B_WIDTH'(-B) : B;
    end

    // One partial product per step, weighted by the combined chunk position
    always_comb begin
        w_a_chunk  = CH'(r_a >> (32'(r_i) * CH));
        w_b_chunk  = CH'(r_b >> (32'(r_j) * CH));
        w_pp       = PW'(w_a_chunk) * PW'(w_b_chunk);
        w_pp_sh    = YW'(w_pp) << ((32'(r_i) + 32'(r_j)) * CH);
        w_acc_next = r_acc + w_pp_sh;
        w_i_last   = (32'(r_i) == NA - 1);
        w_last     = w_i_last && (32'(r_j) == NB - 1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_neg       <= 1'b0;
            r_i         <= '0;
            r_j         <= '0;
            r_acc       <= '0;
            r_y         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= w_a_mag;
                        r_b     <= w_b_mag;
                        r_neg   <= w_a_neg ^ w_b_neg;
                        r_acc   <= '0;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    if (w_i_last) begin
                        r_i <= '0;
                        r_j <= r_j + 1'b1;
                    end else begin
                        r_i <= r_i + 1'b1;
                    end
                    // Sign is applied on the same edge the last partial product lands
                    if (w_last) begin
                        r_y         <= r_neg ? YW'(-w_acc_next) : w_acc_next;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign Y         = r_y;

endmodule

// File: tb/tb_seq_mul_chunked.sv
// Directed and randomised checks of seq_mul_chunked in unsigned, signed
// and CHUNK=8 (24x16) configurations.
module tb_seq_mul_chunked;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        v0, r0, ov0, or0;
    logic [31:0] a0, b0;
    logic [63:0] y0;

    logic        v1, r1, ov1, or1;
    logic [31:0] a1, b1;
    logic [63:0] y1;

    logic        v2, r2, ov2, or2;
    logic [23:0] a2;
    logic [15:0] b2;
    logic [39:0] y2;

    int total = 0;
    int bad   = 0;

    seq_mul_chunked #(.A_WIDTH(32), .B_WIDTH(32), .CHUNK(16), .SIGNED(0)) u_uns (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(r0), .A(a0), .B(b0),
        .out_valid(ov0), .out_ready(or0), .Y(y0));

    seq_mul_chunked #(.A_WIDTH(32), .B_WIDTH(32), .CHUNK(16), .SIGNED(1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .A(a1), .B(b1),
        .out_valid(ov1), .out_ready(or1), .Y(y1));

    seq_mul_chunked #(.A_WIDTH(24), .B_WIDTH(16), .CHUNK(8), .SIGNED(0)) u_c8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(r2), .A(a2), .B(b2),
        .out_valid(ov2), .out_ready(or2), .Y(y2));

    function automatic logic get_rdy(input int sel);
        case (sel)
            0:       return r0;
            1:       return r1;
            default: return r2;
        endcase
    endfunction

    function automatic logic get_ov(input int sel);
        case (sel)
            0:       return ov0;
            1:       return ov1;
            default: return ov2;
        endcase
    endfunction

    function automatic logic [63:0] get_y(input int sel);
        case (sel)
            0:       return y0;
            1:       return y1;
            default: return 64'(y2);
        endcase
    endfunction

    task automatic set_in(input int sel, input logic v, input logic [31:0] a, input logic [31:0] b);
        case (sel)
            0:       begin v0 = v; a0 = a; b0 = b; end
            1:       begin v1 = v; a1 = a; b1 = b; end
            default: begin v2 = v; a2 = a[23:0]; b2 = b[15:0]; end
        endcase
    endtask

    task automatic set_or(input int sel, input logic v);
        case (sel)
            0:       or0 = v;
            1:       or1 = v;
            default: or2 = v;
        endcase
    endtask

    // Full transaction: lat = cycles from accept to out_valid, busy = cycles with in_ready low
    task automatic do_op(input int sel, input logic [31:0] a, input logic [31:0] b, input bit rnd,
                         output logic [63:0] y, output int lat, output int busy, output bit to);
        int n;
        to   = 1'b0;
        lat  = -1;
        busy = 0;
        y    = '0;
        @(negedge clk);
        set_in(sel, 1'b1, a, b);
        set_or(sel, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
        n = 0;
        while (!get_rdy(sel) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            to = 1'b1;
            set_in(sel, 1'b0, 32'd0, 32'd0);
            return;
        end
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (n == 1) set_in(sel, 1'b0, 32'd0, 32'd0);
            if (get_ov(sel) && lat < 0) begin
                lat = n;
                y   = get_y(sel);
            end
            if (get_rdy(sel)) break;
            busy++;
            if (rnd) set_or(sel, 1'($urandom_range(0, 1)));
        end
        if (n >= 100 || lat < 0) to = 1'b1;
        set_or(sel, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(0, 1'b0, 32'd0, 32'd0);
        set_in(1, 1'b0, 32'd0, 32'd0);
        set_in(2, 1'b0, 32'd0, 32'd0);
        or0 = 1'b0; or1 = 1'b0; or2 = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            total++;
            if (get_ov(s) !== 1'b0) begin
                bad++; $display("FAIL reset_out_valid dut=%0d got=%b exp=0", s, get_ov(s));
            end
            total++;
            if (get_rdy(s) !== 1'b1) begin
                bad++; $display("FAIL reset_in_ready dut=%0d got=%b exp=1", s, get_rdy(s));
            end
            total++;
            if (get_y(s) !== 64'd0) begin
                bad++; $display("FAIL reset_y dut=%0d got=%h exp=0", s, get_y(s));
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned();
        logic [31:0] ta [3];
        logic [31:0] tb [3];
        logic [63:0] te [3];
        logic [63:0] y;
        int lat, busy;
        bit to;
        ta[0] = 32'hFFFF_FFFF; tb[0] = 32'hFFFF_FFFF; te[0] = 64'hFFFF_FFFE_0000_0001;
        ta[1] = 32'h0000_0000; tb[1] = 32'hDEAD_BEEF; te[1] = 64'h0;
        ta[2] = 32'h0001_0000; tb[2] = 32'h0001_0000; te[2] = 64'h0000_0001_0000_0000;
        for (int k = 0; k < 3; k++) begin
            do_op(0, ta[k], tb[k], 1'b0, y, lat, busy, to);
            total++;
            if (to || y !== te[k]) begin
                bad++; $display("FAIL uns_product #%0d got=%h exp=%h timeout=%0d", k, y, te[k], to);
            end
            total++;
            if (lat != 5) begin
                bad++; $display("FAIL uns_latency #%0d got=%0d exp=5", k, lat);
            end
            total++;
            if (busy != 5) begin
                bad++; $display("FAIL uns_ready_low #%0d got=%0d exp=5", k, busy);
            end
        end
    endtask

    task automatic test_signed();
        logic [31:0] ta [4];
        logic [31:0] tb [4];
        logic [63:0] te [4];
        logic [63:0] y;
        int lat, busy;
        bit to;
        ta[0] = 32'hFFFF_FFFD; tb[0] = 32'd5;         te[0] = 64'hFFFF_FFFF_FFFF_FFF1;
        ta[1] = 32'hFFFF_FFFF; tb[1] = 32'hFFFF_FFFF; te[1] = 64'h1;
        ta[2] = 32'h8000_0000; tb[2] = 32'h8000_0000; te[2] = 64'h4000_0000_0000_0000;
        ta[3] = 32'h8000_0000; tb[3] = 32'd1;         te[3] = 64'hFFFF_FFFF_8000_0000;
        for (int k = 0; k < 4; k++) begin
            do_op(1, ta[k], tb[k], 1'b0, y, lat, busy, to);
            total++;
            if (to || y !== te[k]) begin
                bad++; $display("FAIL sgn_product #%0d got=%h exp=%h timeout=%0d", k, y, te[k], to);
            end
            total++;
            if (lat != 5) begin
                bad++; $display("FAIL sgn_latency #%0d got=%0d exp=5", k, lat);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        or0 = 1'b0; v0 = 1'b1; a0 = 32'h1234_5678; b0 = 32'h9ABC_DEF0;
        total++;
        if (r0 !== 1'b1) begin
            bad++; $display("FAIL bp_ready_at_accept got=%b exp=1", r0);
        end
        @(negedge clk);
        a0 = 32'd7; b0 = 32'd6;
        n = 0;
        while (ov0 !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (y0 !== 64'h0B00_EA4E_242D_2080 || ov0 !== 1'b1) begin
            bad++; $display("FAIL bp_product got=%h valid=%b exp=0b00ea4e242d2080", y0, ov0);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            total++;
            if (ov0 !== 1'b1 || r0 !== 1'b0 || y0 !== 64'h0B00_EA4E_242D_2080) begin
                bad++; $display("FAIL bp_hold cycle=%0d valid=%b ready=%b y=%h exp valid=1 ready=0 y=0b00ea4e242d2080",
                                k, ov0, r0, y0);
            end
        end
        or0 = 1'b1;
        @(negedge clk);
        total++;
        if (ov0 !== 1'b0 || r0 !== 1'b1) begin
            bad++; $display("FAIL bp_release valid=%b ready=%b exp valid=0 ready=1", ov0, r0);
        end
        @(negedge clk);
        v0 = 1'b0;
        total++;
        if (r0 !== 1'b0) begin
            bad++; $display("FAIL bp_reaccept ready=%b exp=0", r0);
        end
        n = 0;
        while (ov0 !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (ov0 !== 1'b1 || y0 !== 64'd42) begin
            bad++; $display("FAIL bp_second_product got=%h valid=%b exp=2a", y0, ov0);
        end
        @(negedge clk);
        total++;
        if (r0 !== 1'b1) begin
            bad++; $display("FAIL bp_idle_after ready=%b exp=1", r0);
        end
        or0 = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] y;
        int lat, busy;
        bit to, seen;
        @(negedge clk);
        v0 = 1'b1; a0 = 32'd9; b0 = 32'd9; or0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++;
        if (ov0 !== 1'b0 || r0 !== 1'b1 || y0 !== 64'd0) begin
            bad++; $display("FAIL rst_mid_state valid=%b ready=%b y=%h exp valid=0 ready=1 y=0", ov0, r0, y0);
        end
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ov0 === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++; $display("FAIL rst_mid_stale out_valid seen=1 exp=0");
        end
        do_op(0, 32'd7, 32'd6, 1'b0, y, lat, busy, to);
        total++;
        if (to || y !== 64'd42) begin
            bad++; $display("FAIL rst_mid_next got=%h exp=2a timeout=%0d", y, to);
        end
    endtask

    task automatic test_chunk8();
        logic [63:0] y;
        int lat, busy;
        bit to;
        do_op(2, 32'h00FF_FFFF, 32'h0000_FFFF, 1'b0, y, lat, busy, to);
        total++;
        if (to || y !== 64'h0000_00FF_FEFF_0001) begin
            bad++; $display("FAIL c8_product got=%h exp=fffeff0001 timeout=%0d", y, to);
        end
        total++;
        if (lat != 7) begin
            bad++; $display("FAIL c8_latency got=%0d exp=7", lat);
        end
        total++;
        if (busy != 7) begin
            bad++; $display("FAIL c8_ready_low got=%0d exp=7", busy);
        end
        do_op(2, 32'h0080_0000, 32'h0000_8000, 1'b0, y, lat, busy, to);
        total++;
        if (to || y !== 64'h0000_0040_0000_0000) begin
            bad++; $display("FAIL c8_top_bits got=%h exp=4000000000 timeout=%0d", y, to);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic signed [63:0] sa, sb;
        logic [63:0] y, exp;
        int lat, busy, sel;
        bit to;
        for (int k = 0; k < 1000; k++) begin
            sel = k % 2;
            a = $urandom;
            b = $urandom;
            if (k % 50 == 3) a = 32'h8000_0000;
            if (sel == 0) begin
                exp = 64'(a) * 64'(b);
            end else begin
                sa  = {{32{a[31]}}, a};
                sb  = {{32{b[31]}}, b};
                exp = 64'(sa * sb);
            end
            do_op(sel, a, b, 1'b1, y, lat, busy, to);
            total++;
            if (to || y !== exp || lat != 5) begin
                bad++; $display("FAIL rand #%0d sel=%0d a=%h b=%h got=%h exp=%h lat=%0d timeout=%0d",
                                k, sel, a, b, y, exp, lat, to);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_backpressure();
        test_reset_mid_run();
        test_chunk8();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
